exu_div_iter: RTL and testbench

- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the EXU beside the pipelined multiplier. The multiplier forms products; this block inverts them, producing quotient or remainder.
- Non-pipelined: one operation in flight. Uses a valid/busy/finish handshake with flush abort.

---
 rtl/exu_div_iter.sv | 163 ++++++++++++++++
 tb/tb_exu_div_iter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_div_iter.sv
// exu_div_iter: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight. Optional build macro DIV_SHORTCUT_EN lets divide-by-zero
// and |a| < |b| skip the 32 iteration cycles. Results are the same either way.
//
// Handshake: valid is sampled only while idle (busy low) and flush low; a sampled
// valid starts an operation and raises busy on the next cycle. busy stays high
// until the finish cycle. finish is a one-cycle pulse and out is valid in that
// cycle. out then holds its value until the next finish. flush returns to idle at
// the next edge from any state; an aborted operation never produces finish.
module exu_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             sign,
  input  logic             rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem_p;    // partial remainder
  logic [WIDTH-1:0] r_quot;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic [WIDTH-1:0] r_a_orig;   // original dividend, returned as remainder on divide-by-zero
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_rem_sel;
  logic             r_dz;
  logic             r_busy;
  logic             r_finish;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_dz;
  logic             w_short;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_diff_neg;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_result;

  // Operand magnitudes and capture-time flags
  assign w_abs_a = (sign && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (sign && b[WIDTH-1]) ? -b : b;
  assign w_dz    = (b == '0);

`ifdef DIV_SHORTCUT_EN
  // Quotient is trivially 0 (or all ones for dz) and remainder is the dividend
  assign w_short = w_dz || (w_abs_a < w_abs_b);
`else
  assign w_short = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // Two guard bits keep the sign of the difference exact for a 33-bit shifted value.
  assign w_shift    = {r_rem_p, r_quot[WIDTH-1]};
  assign w_diff     = w_shift - {2'b00, r_div};
  assign w_diff_neg = w_diff[WIDTH+1];

  // Sign fix-up and divide-by-zero override, then quotient/remainder select
  assign w_q_fix  = r_dz ? '1 : (r_neg_q ? -r_quot : r_quot);
  assign w_r_fix  = r_dz ? r_a_orig :
                    (r_neg_r ? -r_rem_p[WIDTH-1:0] : r_rem_p[WIDTH-1:0]);
  assign w_result = r_rem_sel ? w_r_fix : w_q_fix;

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem_p   <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_a_orig  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_dz      <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_out     <= '0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_finish <= 1'b0;
          if (valid) begin
            r_div     <= w_abs_b;
            r_a_orig  <= a;
            r_neg_q   <= sign && (a[WIDTH-1] ^ b[WIDTH-1]) && !w_dz;
            r_neg_r   <= sign && a[WIDTH-1];
            r_rem_sel <= rem;
            r_dz      <= w_dz;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            if (w_short) begin
              r_rem_p <= {1'b0, w_abs_a};
              r_quot  <= '0;
              r_state <= S_FIX;
            end else begin
              r_rem_p <= '0;
              r_quot  <= w_abs_a;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (w_diff_neg) begin
            r_rem_p <= w_shift[WIDTH:0];
            r_quot  <= {r_quot[WIDTH-2:0], 1'b0};
          end else begin
            r_rem_p <= w_diff[WIDTH:0];
            r_quot  <= {r_quot[WIDTH-2:0], 1'b1};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_out    <= w_result;
          r_finish <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_finish <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign finish = r_finish;
  assign out    = r_out;

endmodule

// File: tb/tb_exu_div_iter.sv
// Testbench for exu_div_iter: table vectors, handshake/flush/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_exu_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        sign;
  logic        rem;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        finish;
  logic [31:0] out;

  int unsigned cyc_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  exu_div_iter dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .sign   (sign),
    .rem    (rem),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .finish (finish),
    .out    (out)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, got, exp, cyc_cnt);
    end
  endtask

  // Reference model from RV32M rules
  function automatic logic [31:0] ref_div(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rs, input logic rr);
    int sa;
    int sb;
    sa = ra;
    sb = rb;
    if (rb == 32'd0) return rr ? ra : 32'hFFFF_FFFF;
    if (!rs) return rr ? (ra % rb) : (ra / rb);
    if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) return rr ? 32'd0 : ra;
    return rr ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Cycle (relative to the valid cycle N) in which finish is expected
  function automatic int exp_lat(input logic [31:0] ra, input logic [31:0] rb, input logic rs);
`ifdef DIV_SHORTCUT_EN
    if (rb == 32'd0 || mag(ra, rs) < mag(rb, rs)) return 2;
`endif
    return 34;
  endfunction

  // Issue one operation from an idle cycle; returns the finish latency and the
  // absolute cycle of the finish. Ends one cycle after finish (DUT idle again).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input logic tr, input logic [31:0] texp, input bit hold_valid,
                        output int lat, output int unsigned t_fin);
    int busy_bad;
    logic [31:0] e;
    busy_bad = 0;
    a = ta; b = tb_v; sign = ts; rem = tr; valid = 1'b1;
    exp_q.push_back(texp);
    @(posedge clk); #1;
    if (!hold_valid) valid = 1'b0;
    lat = 1;
    if (!busy) busy_bad++;
    while (!finish && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_bad++;
    end
    valid = 1'b0;
    t_fin = cyc_cnt;
    e = exp_q.pop_front();
    if (!finish) begin
      chk("finish_timeout", {31'd0, finish}, 32'd1);
    end else begin
      chk("result", out, e);
    end
    chk("busy_during_op", busy_bad, 0);
    @(posedge clk); #1;
    chk("finish_one_cycle", {31'd0, finish}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Watch n cycles and count finish pulses
  task automatic count_finish(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (finish) cnt++;
    end
  endtask

  initial begin
    int lat;
    int unsigned t1;
    int unsigned t2;
    int nf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rs;
    logic rr;

    vecs[0]  = '{32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000E};
    vecs[1]  = '{32'h0000_0064, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0002};
    vecs[2]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, 32'hFFFF_FFFD};
    vecs[3]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000};
    vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000};
    vecs[6]  = '{32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[7]  = '{32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0005};
    vecs[8]  = '{32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0005};
    vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000};
    vecs[12] = '{32'h0000_0007, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[13] = '{32'hFFFF_FFF0, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFF0};

    // reset
    rst = 1'b1; valid = 1'b0; sign = 1'b0; rem = 1'b0; flush = 1'b0;
    a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_finish", {31'd0, finish}, 32'd0);
    chk("reset_out", out, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // table vectors
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].exp, 1'b0, lat, t1);
      chk("table_latency", lat, exp_lat(vecs[i].a, vecs[i].b, vecs[i].s));
    end

    // valid held during busy: exactly one finish
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b1, lat, t1);
    chk("hold_latency", lat, 34);
    count_finish(40, nf);
    chk("hold_single_finish", nf, 0);

    // back-to-back: second valid in the cycle after finish
    run_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0, lat, t1);
    run_op(32'd20, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, lat, t2);
    chk("b2b_spacing", t2 - t1, 35);

    // flush at CALC cycle 10
    a = 32'd1000; b = 32'd7; sign = 1'b0; rem = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_finish", {31'd0, finish}, 32'd0);
    count_finish(40, nf);
    chk("flush_no_finish", nf, 0);
    run_op(32'd20, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, lat, t1);
    chk("post_flush_latency", lat, 34);

    // flush coincident with valid in idle: valid ignored
    a = 32'd50; b = 32'd5; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush_valid_busy", {31'd0, busy}, 32'd0);
    count_finish(40, nf);
    chk("flush_valid_no_finish", nf, 0);
    chk("flush_valid_out_held", out, 32'd6);

    // asynchronous reset mid-CALC
    a = 32'd1000; b = 32'd7; sign = 1'b0; rem = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_out", out, 32'd0);
    @(negedge clk) rst = 1'b0;
    count_finish(40, nf);
    chk("rst_mid_no_finish", nf, 0);

    // randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 50); end
        4: rb = $urandom_range(1, 255);
        default: ;
      endcase
      run_op(ra, rb, rs, rr, ref_div(ra, rb, rs, rr), 1'b0, lat, t1);
      chk("rand_latency", lat, exp_lat(ra, rb, rs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
